// File: rtl/group_a_mode1_ctrl.sv
// PPI group A mode-1 strobed handshake sequencer: STB_n/IBF input, ACK_n/OBF_n output,
// INTR_A generation and port A input latching. Every output comes straight from a flop.
module group_a_mode1_ctrl #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       nReset,
  input  logic [7:0] controlword,
  input  logic       cw_load,
  input  logic       rd_pa,
  input  logic       wr_pa,
  input  logic [7:0] pa_pins,
  input  logic [3:0] pcu_pins,
  output logic [7:0] pa_in_latch,
  output logic [3:0] pcu_out,
  output logic [3:0] pcu_own,
  output logic       intr_a,
  output logic       mode1_act
);

  typedef enum logic [2:0] {
    IDLE, IN_IDLE, IN_FULL, OUT_IDLE, OUT_FULL, OUT_ACK
  } state_t;

  state_t state, state_d;
  logic [SYNC_STAGES-1:0] stb_sync, ack_sync;
  logic stb_hist, ack_hist;
  logic stb_fall, stb_rise, ack_fall, ack_rise;
  logic ibf, ibf_d, obf_n, obf_n_d, intr, intr_d;
  logic inte_in, inte_in_d, inte_out, inte_out_d;
  logic [7:0] latch_d;
  logic [3:0] own_d;
  logic is_in;

  // PC5 and PC7 are outputs of this block; their pin readback is not needed
  logic unused_pins;
  assign unused_pins = ^{pcu_pins[3], pcu_pins[1]};

  assign stb_fall = stb_hist & ~stb_sync[SYNC_STAGES-1];
  assign stb_rise = ~stb_hist & stb_sync[SYNC_STAGES-1];
  assign ack_fall = ack_hist & ~ack_sync[SYNC_STAGES-1];
  assign ack_rise = ~ack_hist & ack_sync[SYNC_STAGES-1];
  assign is_in    = (state == IN_IDLE) || (state == IN_FULL);

  always_comb begin
    state_d    = state;
    ibf_d      = ibf;
    obf_n_d    = obf_n;
    intr_d     = intr;
    inte_in_d  = inte_in;
    inte_out_d = inte_out;
    latch_d    = pa_in_latch;
    if (cw_load) begin
      if (controlword[7]) begin
        ibf_d      = 1'b0;
        obf_n_d    = 1'b1;
        intr_d     = 1'b0;
        inte_in_d  = 1'b0;
        inte_out_d = 1'b0;
        if (controlword[6:5] == 2'b01)
          state_d = controlword[4] ? IN_IDLE : OUT_IDLE;
        else
          state_d = IDLE;
      end else if (controlword[3:1] == 3'd4) begin
        // disabling INTE drops a pending request; enabling never raises one
        inte_in_d = controlword[0];
        if (!controlword[0] && is_in) intr_d = 1'b0;
      end else if (controlword[3:1] == 3'd6) begin
        inte_out_d = controlword[0];
        if (!controlword[0] && !is_in) intr_d = 1'b0;
      end
    end else begin
      case (state)
        IN_IDLE: if (stb_fall) begin
          latch_d = pa_pins;
          ibf_d   = 1'b1;
          state_d = IN_FULL;
        end
        IN_FULL: if (rd_pa) begin
          intr_d  = 1'b0;
          ibf_d   = 1'b0;
          state_d = IN_IDLE;
        end else if (stb_rise) begin
          intr_d = inte_in;
        end
        OUT_IDLE, OUT_FULL, OUT_ACK: if (wr_pa) begin
          obf_n_d = 1'b0;
          intr_d  = 1'b0;
          state_d = OUT_FULL;
        end else if (state == OUT_FULL && ack_fall) begin
          obf_n_d = 1'b1;
          state_d = OUT_ACK;
        end else if (state == OUT_ACK && ack_rise) begin
          intr_d  = inte_out;
          state_d = OUT_IDLE;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    own_d = 4'b0000;
    if (state_d == IN_IDLE || state_d == IN_FULL) own_d = 4'b0011;
    else if (state_d != IDLE)                     own_d = 4'b1100;
  end

  always_ff @(posedge clk) begin
    if (!nReset) begin
      state       <= IDLE;
      stb_sync    <= '1;
      ack_sync    <= '1;
      stb_hist    <= 1'b1;
      ack_hist    <= 1'b1;
      ibf         <= 1'b0;
      obf_n       <= 1'b1;
      intr        <= 1'b0;
      inte_in     <= 1'b0;
      inte_out    <= 1'b0;
      pa_in_latch <= 8'h00;
      pcu_own     <= 4'b0000;
      mode1_act   <= 1'b0;
    end else begin
      state       <= state_d;
      stb_sync    <= {stb_sync[SYNC_STAGES-2:0], pcu_pins[0]};
      ack_sync    <= {ack_sync[SYNC_STAGES-2:0], pcu_pins[2]};
      stb_hist    <= stb_sync[SYNC_STAGES-1];
      ack_hist    <= ack_sync[SYNC_STAGES-1];
      ibf         <= ibf_d;
      obf_n       <= obf_n_d;
      intr        <= intr_d;
      inte_in     <= inte_in_d;
      inte_out    <= inte_out_d;
      pa_in_latch <= latch_d;
      pcu_own     <= own_d;
      mode1_act   <= (state_d != IDLE);
    end
  end

  assign pcu_out = {obf_n, 1'b0, ibf, 1'b0};
  assign intr_a  = intr;

endmodule

// File: tb/tb_group_a_mode1_ctrl.sv
// Directed bench for group_a_mode1_ctrl: expectations are queued as stimulus is applied
// and drained against the DUT outputs one cycle-accurate sample point at a time.
module tb_group_a_mode1_ctrl;
  logic       clk = 1'b0;
  logic       nReset;
  logic [7:0] controlword;
  logic       cw_load, rd_pa, wr_pa;
  logic [7:0] pa_pins;
  logic [3:0] pcu_pins;
  logic [7:0] pa_in_latch;
  logic [3:0] pcu_out, pcu_own;
  logic       intr_a, mode1_act;

  localparam int S_OWN = 0, S_OUT = 1, S_INTR = 2, S_MODE = 3, S_LATCH = 4;

  typedef struct {
    string      tag;
    int         sel;
    logic [7:0] exp;
  } chk_t;

  chk_t sb[$];
  int   passed = 0;
  int   total  = 0;

  group_a_mode1_ctrl #(.SYNC_STAGES(2)) dut (
    .clk(clk), .nReset(nReset), .controlword(controlword), .cw_load(cw_load),
    .rd_pa(rd_pa), .wr_pa(wr_pa), .pa_pins(pa_pins), .pcu_pins(pcu_pins),
    .pa_in_latch(pa_in_latch), .pcu_out(pcu_out), .pcu_own(pcu_own),
    .intr_a(intr_a), .mode1_act(mode1_act)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input string tag, input int sel, input logic [7:0] exp);
    chk_t c;
    c.tag = tag;
    c.sel = sel;
    c.exp = exp;
    sb.push_back(c);
  endtask

  function automatic logic [7:0] observe(input int sel);
    case (sel)
      S_OWN:   return {4'h0, pcu_own};
      S_OUT:   return {4'h0, pcu_out};
      S_INTR:  return {7'h0, intr_a};
      S_MODE:  return {7'h0, mode1_act};
      default: return pa_in_latch;
    endcase
  endfunction

  task automatic drain();
    chk_t c;
    logic [7:0] obs;
    while (sb.size() > 0) begin
      c   = sb.pop_front();
      obs = observe(c.sel);
      total++;
      assert (obs === c.exp) passed++;
      else $error("FAIL %s: observed %h expected %h", c.tag, obs, c.exp);
    end
  endtask

  task automatic cw(input logic [7:0] w);
    controlword = w;
    cw_load     = 1'b1;
    tick();
    cw_load     = 1'b0;
  endtask

  task automatic pulse_rd();
    rd_pa = 1'b1;
    tick();
    rd_pa = 1'b0;
  endtask

  initial begin
    nReset = 1'b0; controlword = 8'h00; cw_load = 1'b0; rd_pa = 1'b0; wr_pa = 1'b0;
    pa_pins = 8'h00; pcu_pins = 4'b1111;
    tick(2);
    push("rst_own", S_OWN, 8'h00); push("rst_out", S_OUT, 8'h08);
    push("rst_intr", S_INTR, 8'h00); push("rst_mode", S_MODE, 8'h00);
    push("rst_latch", S_LATCH, 8'h00);
    drain();
    nReset = 1'b1;

    // input mode with INTE_IN on
    cw(8'hB0);
    push("in_mode", S_MODE, 8'h01); push("in_own", S_OWN, 8'h03); push("in_out0", S_OUT, 8'h08);
    drain();
    cw(8'h09);
    pa_pins = 8'h5A; pcu_pins = 4'b1110;
    tick(2);
    push("in_ibf_early", S_OUT, 8'h08); drain();
    tick();
    push("in_ibf", S_OUT, 8'h0A); push("in_latch", S_LATCH, 8'h5A); drain();
    pcu_pins = 4'b1111;
    tick(2);
    push("in_intr_early", S_INTR, 8'h00); drain();
    tick();
    push("in_intr", S_INTR, 8'h01); drain();

    // overrun: second strobe while IBF is set must not overwrite
    pa_pins = 8'hC3; pcu_pins = 4'b1110;
    tick(3);
    pcu_pins = 4'b1111;
    tick(3);
    push("ovr_latch", S_LATCH, 8'h5A); push("ovr_ibf", S_OUT, 8'h0A); drain();
    pulse_rd();
    push("rd_ibf", S_OUT, 8'h08); push("rd_intr", S_INTR, 8'h00); drain();
    pulse_rd();
    push("rd_idle_out", S_OUT, 8'h08); push("rd_idle_latch", S_LATCH, 8'h5A); drain();

    // input with INTE_IN left off
    cw(8'hB0);
    pa_pins = 8'h3C; pcu_pins = 4'b1110;
    tick(3);
    push("noint_ibf", S_OUT, 8'h0A); push("noint_latch", S_LATCH, 8'h3C);
    push("noint_intr0", S_INTR, 8'h00); drain();
    pcu_pins = 4'b1111;
    tick(3);
    push("noint_intr1", S_INTR, 8'h00); drain();
    pulse_rd();
    push("noint_rd", S_OUT, 8'h08); push("noint_intr2", S_INTR, 8'h00); drain();

    // mode change while a request is pending
    cw(8'hB0); cw(8'h09);
    pcu_pins = 4'b1110; tick(3);
    pcu_pins = 4'b1111; tick(3);
    push("mc_intr_pre", S_INTR, 8'h01); drain();
    cw(8'h80);
    push("mc_mode", S_MODE, 8'h00); push("mc_own", S_OWN, 8'h00);
    push("mc_intr", S_INTR, 8'h00); push("mc_out", S_OUT, 8'h08); drain();

    // output mode with INTE_OUT on
    cw(8'hA0); cw(8'h0D);
    push("out_own", S_OWN, 8'h0C); push("out_mode", S_MODE, 8'h01); drain();
    wr_pa = 1'b1; tick(); wr_pa = 1'b0;
    push("out_obf", S_OUT, 8'h00); push("out_intr0", S_INTR, 8'h00); drain();
    pcu_pins = 4'b1011;
    tick(2);
    push("ack_obf_early", S_OUT, 8'h00); drain();
    tick();
    push("ack_obf", S_OUT, 8'h08); drain();
    pcu_pins = 4'b1111;
    tick(2);
    push("ack_intr_early", S_INTR, 8'h00); drain();
    tick();
    push("ack_intr", S_INTR, 8'h01); drain();
    cw(8'h0C);
    push("inte_off", S_INTR, 8'h00); drain();

    // reset in the middle of OUT_FULL
    wr_pa = 1'b1; tick(); wr_pa = 1'b0;
    push("out_full", S_OUT, 8'h00); drain();
    nReset = 1'b0; tick(); nReset = 1'b1;
    push("mr_own", S_OWN, 8'h00); push("mr_out", S_OUT, 8'h08);
    push("mr_intr", S_INTR, 8'h00); push("mr_mode", S_MODE, 8'h00); drain();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
